// File: rtl/morse_tx.sv
// Morse/pattern LED transmitter: shifts a captured bit pattern out MSB-first,
// one symbol per programmable period, with optional gapped repetition.
module morse_tx #(
    parameter  int MAXLEN   = 16,
    parameter  int DIV_W    = 26,
    parameter  int GAP_SYMS = 7,
    localparam int LW       = $clog2(MAXLEN + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [LW-1:0]     length,
    input  logic [DIV_W-1:0]  divider,
    input  logic              start,
    input  logic              repeat_en,
    input  logic              abort,
    output logic              led,
    output logic              busy,
    output logic              done,
    output logic              tick
);

    localparam int GW = $clog2(GAP_SYMS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]        state;
    logic [MAXLEN-1:0] shreg;
    logic [MAXLEN-1:0] cap_pattern;
    logic [LW-1:0]     bit_cnt;
    logic [LW-1:0]     cap_len;
    logic [LW-1:0]     len_clamped;
    logic [GW-1:0]     gap_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  cap_div;
    logic              sym_end;

    assign len_clamped = (length > LW'(MAXLEN)) ? LW'(MAXLEN) : length;

    // The divider counter sits at 0 on the last cycle of every symbol period.
    assign sym_end = (state != S_IDLE) && (div_cnt == '0);
    assign busy    = (state != S_IDLE);
    assign tick    = sym_end;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before this edge, regardless of order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            led         <= 1'b0;
            done        <= 1'b0;
            shreg       <= '0;
            cap_pattern <= '0;
            bit_cnt     <= '0;
            cap_len     <= '0;
            gap_cnt     <= '0;
            div_cnt     <= '0;
            cap_div     <= '0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && abort) begin
                state   <= S_IDLE;
                led     <= 1'b0;
                shreg   <= '0;
                bit_cnt <= '0;
                gap_cnt <= '0;
                div_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if (length != '0) begin
                                state       <= S_SEND;
                                cap_pattern <= pattern;
                                cap_len     <= len_clamped;
                                cap_div     <= divider;
                                shreg       <= pattern;
                                bit_cnt     <= len_clamped;
                                div_cnt     <= divider;
                                led         <= pattern[MAXLEN-1];
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end

                    S_SEND: begin
                        if (!sym_end) begin
                            div_cnt <= div_cnt - DIV_W'(1);
                        end else if (bit_cnt == LW'(1)) begin
                            // Last symbol: repeat_en is only looked at here.
                            shreg   <= '0;
                            bit_cnt <= '0;
                            led     <= 1'b0;
                            if (repeat_en) begin
                                state   <= S_GAP;
                                gap_cnt <= GW'(GAP_SYMS);
                                div_cnt <= cap_div;
                            end else begin
                                state   <= S_IDLE;
                                done    <= 1'b1;
                                div_cnt <= '0;
                            end
                        end else begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt - LW'(1);
                            led     <= shreg[MAXLEN-2];
                            div_cnt <= cap_div;
                        end
                    end

                    S_GAP: begin
                        if (!sym_end) begin
                            div_cnt <= div_cnt - DIV_W'(1);
                        end else begin
                            div_cnt <= cap_div;
                            if (gap_cnt == GW'(1)) begin
                                state   <= S_SEND;
                                gap_cnt <= '0;
                                shreg   <= cap_pattern;
                                bit_cnt <= cap_len;
                                led     <= cap_pattern[MAXLEN-1];
                            end else begin
                                gap_cnt <= gap_cnt - GW'(1);
                            end
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                        led   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx: expected per-cycle {led,busy,done,tick} are
// queued as stimulus is set up and compared one entry per clock cycle.
module tb_morse_tx;

    localparam int MAXLEN = 16;
    localparam int DIV_W  = 26;
    localparam int LW     = $clog2(MAXLEN + 1);

    typedef struct packed {
        logic led;
        logic busy;
        logic done;
        logic tick;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [MAXLEN-1:0] pattern = '0;
    logic [LW-1:0]     length = '0;
    logic [DIV_W-1:0]  divider = '0;
    logic              start = 1'b0;
    logic              repeat_en = 1'b0;
    logic              abort = 1'b0;
    logic              led, busy, done, tick;

    exp_t  sb_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    tick_seen = 0;
    string cur_tag = "reset";

    morse_tx #(.MAXLEN(MAXLEN), .DIV_W(DIV_W), .GAP_SYMS(7)) dut (
        .clock     (clock),
        .reset     (reset),
        .pattern   (pattern),
        .length    (length),
        .divider   (divider),
        .start     (start),
        .repeat_en (repeat_en),
        .abort     (abort),
        .led       (led),
        .busy      (busy),
        .done      (done),
        .tick      (tick)
    );

    always #5 clock = ~clock;

    task automatic push(input logic l, input logic b, input logic d, input logic t);
        exp_t e;
        e.led = l; e.busy = b; e.done = d; e.tick = t;
        sb_q.push_back(e);
    endtask

    // Queues up to 'limit' cycles of a SEND of 'len' symbols.
    task automatic push_send(input logic [MAXLEN-1:0] pat, input int len,
                             input int div, input int limit);
        int n = 0;
        for (int i = 0; i < len; i++)
            for (int c = 0; c <= div; c++)
                if (n < limit) begin
                    push(pat[MAXLEN-1-i], 1'b1, 1'b0, c == div);
                    n++;
                end
    endtask

    task automatic push_gap(input int div, input int limit);
        int n = 0;
        for (int g = 0; g < 7; g++)
            for (int c = 0; c <= div; c++)
                if (n < limit) begin
                    push(1'b0, 1'b1, 1'b0, c == div);
                    n++;
                end
    endtask

    // Lets one rising edge pass, then compares outputs against the queue head.
    task automatic step_chk();
        exp_t e;
        exp_t obs;
        @(negedge clock);
        cyc++;
        obs = '{led: led, busy: busy, done: done, tick: tick};
        if (tick === 1'b1) tick_seen++;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s cyc=%0d scoreboard empty observed=%b", cur_tag, cyc, obs);
        end else begin
            e = sb_q.pop_front();
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s cyc=%0d {led,busy,done,tick} observed=%b expected=%b",
                       cur_tag, cyc, obs, e);
            end
        end
    endtask

    task automatic drain();
        while (sb_q.size() > 0) step_chk();
    endtask

    task automatic launch(input string tag);
        cur_tag = tag;
        cyc = 0;
        start = 1'b1;
        step_chk();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        push(0, 0, 0, 0); push(0, 0, 0, 0);
        step_chk(); step_chk();
        @(negedge clock);
        reset = 1'b0;

        // Single send: 1,0,1,0,1 three cycles each, done on cycle 16
        pattern = 16'b1010100000000000; length = 5; divider = 2; repeat_en = 0;
        push_send(pattern, 5, 2, 1000); push(0, 0, 1, 0); push(0, 0, 0, 0);
        launch("single");
        drain();

        // Repeat with gap, then abort in the middle of the second gap
        pattern = 16'b1110000000000000; length = 3; divider = 0; repeat_en = 1;
        push_send(pattern, 3, 0, 1000); push_gap(0, 1000);
        push_send(pattern, 3, 0, 1000); push_gap(0, 3);
        launch("repeat");
        drain();
        cur_tag = "abort_gap";
        abort = 1'b1;
        push(0, 0, 0, 0);
        step_chk();
        abort = 1'b0; repeat_en = 1'b0;
        push(0, 0, 0, 0);
        step_chk();

        // length=0: done next cycle, never busy
        pattern = 16'hFFFF; length = 0; divider = 3;
        push(0, 0, 1, 0); push(0, 0, 0, 0);
        launch("len0");
        drain();

        // length=31 clamps to 16 symbols
        pattern = 16'hA5C3; length = 31; divider = 0;
        push_send(pattern, 16, 0, 1000); push(0, 0, 1, 0); push(0, 0, 0, 0);
        launch("len31");
        drain();

        // start together with abort in IDLE is ignored
        cur_tag = "start_abort";
        pattern = 16'hF000; length = 4; divider = 0;
        start = 1'b1; abort = 1'b1;
        push(0, 0, 0, 0); push(0, 0, 0, 0);
        step_chk(); step_chk();
        start = 1'b0; abort = 1'b0;

        // start and input changes while busy have no effect
        pattern = 16'b1100100000000000; length = 4; divider = 1;
        push_send(pattern, 4, 1, 1000); push(0, 0, 1, 0); push(0, 0, 0, 0);
        launch("busy_ignore");
        step_chk(); step_chk(); step_chk();
        start = 1'b1; pattern = 16'h3FFF; length = 2; divider = 5;
        step_chk(); step_chk();
        start = 1'b0;
        drain();

        // Reset during the 3rd symbol of a 5-symbol send, then a full send
        pattern = 16'b1010100000000000; length = 5; divider = 2;
        push_send(pattern, 5, 2, 7);
        launch("reset_mid");
        drain();
        reset = 1'b1;
        push(0, 0, 0, 0);
        step_chk();
        reset = 1'b0;
        push(0, 0, 0, 0);
        step_chk();
        push_send(pattern, 5, 2, 1000); push(0, 0, 1, 0); push(0, 0, 0, 0);
        launch("after_reset");
        drain();

        // tick spacing: 4 ticks, the last one right before done
        pattern = 16'b1001000000000000; length = 4; divider = 4;
        push_send(pattern, 4, 4, 1000); push(0, 0, 1, 0); push(0, 0, 0, 0);
        launch("tick");
        tick_seen = 0;
        drain();
        total++;
        assert (tick_seen == 4) else begin
            bad++;
            $error("FAIL tick_count observed=%0d expected=4", tick_seen);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 Parameter MAXLEN, default 16, maximum number of symbol bits per pattern (>=2).
REQ-002 Parameter DIV_W, default 26, width of the symbol-period divider.
REQ-003 Parameter GAP_SYMS, default 7, number of off symbols inserted between repetitions (>=1).
REQ-004 Derived LW = clog2(MAXLEN+1), width of the length field.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pattern  input  MAXLEN  symbol bits; MSB is sent first; 1 = LED on, 0 = LED off.
REQ-008 length  input  LW  number of pattern bits to send, counted from the MSB.
REQ-009 divider  input  DIV_W  symbol period minus one, in clock cycles.
REQ-010 start  input  1  request to begin transmission; sampled only in IDLE.
REQ-011 repeat_en  input  1  loop the pattern, with a gap between repetitions, until abort.
REQ-012 abort  input  1  terminate transmission immediately.
REQ-013 led  output  1  registered Morse output.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  single-cycle pulse on normal completion.
REQ-016 tick  output  1  single-cycle pulse on the last clock cycle of each symbol period, SEND and GAP.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SEND, GAP.
REQ-018 In IDLE, start=1, abort=0 and length!=0 SHALL capture pattern, length and divider into internal registers and move to SEND on the next edge.
- length > MAXLEN is clamped to MAXLEN.
REQ-019 In IDLE, start=1, abort=0 and length=0 SHALL keep the FSM in IDLE, with done=1 on the next cycle and led=0.
REQ-020 In SEND, led SHALL equal the current symbol bit from the first cycle after capture.
- Each symbol lasts exactly captured_divider+1 cycles.
- divider=0 gives one cycle per symbol.
REQ-021 When a SEND symbol period ends:
- the shift register shifts left by one;
- the remaining-bit counter decrements;
- the next symbol appears on led on the following cycle, with no dead cycle.
REQ-022 When the last symbol period ends with repeat_en=0, the FSM SHALL enter IDLE, with led=0 and done=1 for exactly that next cycle.
REQ-023 When the last symbol period ends with repeat_en=1, the FSM SHALL enter GAP, with led=0 for GAP_SYMS symbol periods.
- It then re-enters SEND with the captured pattern reloaded.
- done SHALL NOT pulse.
REQ-024 repeat_en SHALL be sampled only at the end of the last symbol of each repetition.
REQ-025 abort=1 in SEND or GAP SHALL force IDLE on the next edge, with led=0, done=0 and all counters cleared.
REQ-026 In IDLE, abort=1 SHALL take priority over start, and the start SHALL be ignored.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 Changes to pattern, length or divider while busy SHALL have no effect on the transmission in progress.
REQ-029 In IDLE, led=0 and tick=0.
REQ-030 The divider counter SHALL be DIV_W bits wide.
- It counts down from captured_divider to 0.
- It reloads on reaching 0, with no wrap past 0.

Reset
REQ-031 reset=1 at a clock edge SHALL force the following on that edge, overriding all other inputs:
- state IDLE;
- led=0, busy=0, done=0, tick=0;
- shift register, bit counter, gap counter and divider counter all 0.
REQ-032 Reset asserted mid-transmission SHALL abandon the transmission without a done pulse; the first start after reset deasserts SHALL be accepted normally.

Verification
REQ-033 Bench SHALL cover these directed scenarios:
- Single send: pattern=16'b1010100000000000, length=5, divider=2, start pulse -> led holds 1,0,1,0,1 for 3 cycles each (15 cycles); done pulses once on cycle 16; busy is high for cycles 1-15.
- Repeat: pattern=16'b1110000000000000, length=3, divider=0, repeat_en=1 -> led 1,1,1, then 0 x7, then 1,1,1 repeating; no done pulses; abort mid-gap -> IDLE and led=0 next cycle.
- Edge lengths: length=0 with start -> done on the next cycle, busy stays 0. length=31 with MAXLEN=16 -> exactly 16 symbols sent.
- Simultaneous events: start+abort in IDLE -> stays IDLE. start during SEND -> ignored. pattern changed during SEND -> output unchanged.
- Reset mid-operation: reset in the 3rd symbol of a 5-symbol send -> all outputs 0 on the next cycle, no done; a subsequent start sends the full pattern.
- tick check: divider=4, length=4 -> exactly 4 tick pulses, each 5 cycles apart, with the last coinciding with the cycle before done.
